// File: rtl/pulse_arbiter_if.sv
// Registered valid/ready pulse stream from the arbiter to the pulse FIFO write port.
// The master drives a tagged pulse; the slave answers with out_ready.
interface pulse_arbiter_if #(
  parameter int SID_BITS = 2
);
  logic                out_valid;
  logic [31:0]         out_ts;
  logic [15:0]         out_length;
  logic [SID_BITS-1:0] out_sensor;
  logic                out_ready;

  modport master (
    output out_valid, out_ts, out_length, out_sensor,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ts, out_length, out_sensor,
    output out_ready
  );
endinterface

// File: rtl/pulse_arbiter.sv
// Buffers one pulse per sensor and merges them round-robin into a single
// registered valid/ready stream, counting pulses lost to slot overrun.
module pulse_arbiter #(
  parameter int N_SENSORS = 4,
  parameter int SID_BITS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SENSORS-1:0]    pulse_strb,
  input  logic [32*N_SENSORS-1:0] pulse_ts,
  input  logic [16*N_SENSORS-1:0] pulse_len,
  input  logic                    clear_drops,
  output logic [15:0]             drop_count,
  output logic [N_SENSORS-1:0]    drop_flags,
  pulse_arbiter_if.master         out_bus
);

  logic                slot_full_reg [N_SENSORS];
  logic [31:0]         slot_ts_reg   [N_SENSORS];
  logic [15:0]         slot_len_reg  [N_SENSORS];
  logic [SID_BITS-1:0] rr_reg;

  logic                out_valid_reg;
  logic [31:0]         out_ts_reg;
  logic [15:0]         out_len_reg;
  logic [SID_BITS-1:0] out_sensor_reg;

  logic [15:0]          drop_count_reg, drop_count_next;
  logic [N_SENSORS-1:0] drop_flags_reg, drop_flags_next;

  logic                 out_free;
  logic                 grant_any;
  logic [SID_BITS-1:0]  grant_idx;
  logic [N_SENSORS-1:0] take;
  logic [N_SENSORS-1:0] accept;
  logic [N_SENSORS-1:0] drop;

  assign out_free = !out_valid_reg || out_bus.out_ready;

  // Round-robin search starting one past the last granted sensor.
  always_comb begin
    int                  cand;
    logic [SID_BITS-1:0] cand_idx;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= N_SENSORS; off++) begin
      cand     = (int'(rr_reg) + off) % N_SENSORS;
      cand_idx = SID_BITS'(cand);
      if (!grant_any && slot_full_reg[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_slot
      assign take[gi]   = out_free && grant_any && (grant_idx == SID_BITS'(gi));
      // A slot being emptied by this cycle's grant may accept a new pulse.
      assign accept[gi] = pulse_strb[gi] && (!slot_full_reg[gi] || take[gi]);
      assign drop[gi]   = pulse_strb[gi] && !accept[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          slot_full_reg[gi] <= 1'b0;
          slot_ts_reg[gi]   <= '0;
          slot_len_reg[gi]  <= '0;
        end else if (accept[gi]) begin
          slot_full_reg[gi] <= 1'b1;
          slot_ts_reg[gi]   <= pulse_ts[32*gi +: 32];
          slot_len_reg[gi]  <= pulse_len[16*gi +: 16];
        end else if (take[gi]) begin
          slot_full_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_ts_reg     <= '0;
      out_len_reg    <= '0;
      out_sensor_reg <= '0;
      rr_reg         <= SID_BITS'(N_SENSORS - 1);
    end else if (out_free) begin
      if (grant_any) begin
        out_valid_reg  <= 1'b1;
        out_ts_reg     <= slot_ts_reg[grant_idx];
        out_len_reg    <= slot_len_reg[grant_idx];
        out_sensor_reg <= grant_idx;
        rr_reg         <= grant_idx;
      end else begin
        out_valid_reg  <= 1'b0;
      end
    end
  end

  // Clear applies first so same-cycle drops are still recorded.
  always_comb begin
    logic [16:0] drop_sum;
    drop_sum = clear_drops ? 17'd0 : {1'b0, drop_count_reg};
    for (int i = 0; i < N_SENSORS; i++) begin
      drop_sum = drop_sum + 17'(drop[i]);
    end
    drop_count_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    drop_flags_next = (clear_drops ? '0 : drop_flags_reg) | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_reg <= '0;
      drop_flags_reg <= '0;
    end else begin
      drop_count_reg <= drop_count_next;
      drop_flags_reg <= drop_flags_next;
    end
  end

  assign out_bus.out_valid  = out_valid_reg;
  assign out_bus.out_ts     = out_ts_reg;
  assign out_bus.out_length = out_len_reg;
  assign out_bus.out_sensor = out_sensor_reg;
  assign drop_count         = drop_count_reg;
  assign drop_flags         = drop_flags_reg;

endmodule
